// File: rtl/vga_sync_monitor.sv
// VGA timing monitor: recovers pixel position from registered syncs, verifies line/frame lengths.
// Define VGA_MON_CHECKSUM_EN to build the per-frame RGB checksum; otherwise frame_sum_o is tied to 0.
module vga_sync_monitor #(
  parameter int unsigned COLOR_BITS = 24,
  parameter int unsigned H_VIS      = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VIS      = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    hsync_ni,
  input  logic                    vsync_ni,
  input  logic [COLOR_BITS/3-1:0] red_i,
  input  logic [COLOR_BITS/3-1:0] green_i,
  input  logic [COLOR_BITS/3-1:0] blue_i,
  output logic [9:0]              hpos_o,
  output logic [9:0]              vpos_o,
  output logic                    active_o,
  output logic                    locked_o,
  output logic                    frame_done_o,
  output logic [15:0]             frame_sum_o,
  output logic                    err_hlen_o,
  output logic                    err_vlen_o
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_VIS);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_VIS);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LEN   = 10'(V_TOTAL);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_e;

  state_e     state_q, state_d;
  logic       hs_q, hs_d, vs_q, vs_d;
  logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, lcnt_q, lcnt_d;
  logic       armed_q, armed_d;
  logic       seen_h_q, seen_h_d;
  logic       lines_ok_q, lines_ok_d;
  logic       err_h_q, err_h_d, err_v_q, err_v_d;
  logic       done_q, done_d;
  logic       act_q, act_d;
  logic [9:0] hpos_q, hpos_d, vpos_q, vpos_d;

  logic hfall, vfall, line_bad, frame_bad, end_good;

  always_comb begin
    hs_d      = hsync_ni;
    vs_d      = vsync_ni;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;
    hfall     = hs_prev_q & ~hs_q;
    vfall     = vs_prev_q & ~vs_q;

    hcnt_d = hcnt_q;
    if (hfall)              hcnt_d = '0;
    else if (hcnt_q != '1)  hcnt_d = hcnt_q + 10'd1;

    // An armed vsync fall (or one coinciding with this hsync fall) restarts the row count.
    vcnt_d  = vcnt_q;
    armed_d = armed_q;
    if (hfall) begin
      armed_d = 1'b0;
      if (vfall || armed_q)   vcnt_d = '0;
      else if (vcnt_q != '1)  vcnt_d = vcnt_q + 10'd1;
    end else if (vfall) begin
      armed_d = 1'b1;
    end

    seen_h_d = seen_h_q | hfall;
    line_bad = hfall & seen_h_q & (hcnt_q != H_LAST);

    // An hsync fall coinciding with the vsync fall is the first line of the new frame.
    lcnt_d = lcnt_q;
    if (vfall)                    lcnt_d = hfall ? 10'd1 : 10'd0;
    else if (hfall && lcnt_q != '1) lcnt_d = lcnt_q + 10'd1;
    frame_bad = (lcnt_q != V_LEN);

    lines_ok_d = lines_ok_q;
    if (vfall)         lines_ok_d = 1'b1;
    else if (line_bad) lines_ok_d = 1'b0;
    end_good = vfall & ~frame_bad & lines_ok_q & ~line_bad;
  end

  always_comb begin
    state_d = state_q;
    err_h_d = err_h_q;
    err_v_d = err_v_q;
    done_d  = 1'b0;
    case (state_q)
      SEARCH: if (vfall) state_d = VERIFY;
      VERIFY: if (end_good) state_d = LOCKED;
      LOCKED: begin
        if (line_bad) begin
          state_d = SEARCH;
          err_h_d = 1'b1;
        end
        if (vfall && frame_bad) begin
          state_d = SEARCH;
          err_v_d = 1'b1;
        end
        done_d = end_good;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    act_d  = (state_q == LOCKED) &&
             (hcnt_d >= H_START) && (hcnt_d < H_END) &&
             (vcnt_d >= V_START) && (vcnt_d < V_END);
    hpos_d = act_d ? (hcnt_d - H_START) : '0;
    vpos_d = act_d ? (vcnt_d - V_START) : '0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= SEARCH;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      hs_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      lcnt_q     <= '0;
      armed_q    <= 1'b0;
      seen_h_q   <= 1'b0;
      lines_ok_q <= 1'b0;
      err_h_q    <= 1'b0;
      err_v_q    <= 1'b0;
      done_q     <= 1'b0;
      act_q      <= 1'b0;
      hpos_q     <= '0;
      vpos_q     <= '0;
    end else begin
      state_q    <= state_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      hs_prev_q  <= hs_prev_d;
      vs_prev_q  <= vs_prev_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      lcnt_q     <= lcnt_d;
      armed_q    <= armed_d;
      seen_h_q   <= seen_h_d;
      lines_ok_q <= lines_ok_d;
      err_h_q    <= err_h_d;
      err_v_q    <= err_v_d;
      done_q     <= done_d;
      act_q      <= act_d;
      hpos_q     <= hpos_d;
      vpos_q     <= vpos_d;
    end
  end

`ifdef VGA_MON_CHECKSUM_EN
  logic [COLOR_BITS/3-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [15:0]             acc_q, acc_d, fsum_q, fsum_d;
  logic [15:0]             pix_sum;

  always_comb begin
    red_d   = red_i;
    green_d = green_i;
    blue_d  = blue_i;
    pix_sum = 16'(red_q) + 16'(green_q) + 16'(blue_q);
    acc_d   = (vfall ? 16'd0 : acc_q) + (act_d ? pix_sum : 16'd0);
    fsum_d  = done_d ? acc_q : fsum_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      acc_q   <= '0;
      fsum_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      acc_q   <= acc_d;
      fsum_q  <= fsum_d;
    end
  end

  assign frame_sum_o = fsum_q;
`else
  logic unused_rgb;
  assign unused_rgb  = ^{red_i, green_i, blue_i};
  assign frame_sum_o = '0;
`endif

  assign hpos_o       = hpos_q;
  assign vpos_o       = vpos_q;
  assign active_o     = act_q;
  assign locked_o     = (state_q == LOCKED);
  assign frame_done_o = done_q;
  assign err_hlen_o   = err_h_q;
  assign err_vlen_o   = err_v_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a reduced 8x6 raster so each frame is 165 cycles.
module tb_vga_sync_monitor;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

`ifdef VGA_MON_CHECKSUM_EN
  localparam int SUM_B = 48;
  localparam int SUM_C = 720;
  localparam int SUM_K = 'h8F70;
`else
  localparam int SUM_B = 0;
  localparam int SUM_C = 0;
  localparam int SUM_K = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_ni, hsync_ni, vsync_ni;
  logic [7:0] red_i, green_i, blue_i;
  logic [9:0] hpos_o, vpos_o;
  logic       active_o, locked_o, frame_done_o, err_hlen_o, err_vlen_o;
  logic [15:0] frame_sum_o;

  vga_sync_monitor #(
    .COLOR_BITS(24),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni), .hsync_ni(hsync_ni), .vsync_ni(vsync_ni),
    .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .hpos_o(hpos_o), .vpos_o(vpos_o), .active_o(active_o), .locked_o(locked_o),
    .frame_done_o(frame_done_o), .frame_sum_o(frame_sum_o),
    .err_hlen_o(err_hlen_o), .err_vlen_o(err_vlen_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled on the falling edge.
  logic prev_locked = 1'b0, prev_errh = 1'b0, prev_errv = 1'b0, seen_act = 1'b0;
  int lock_rise_cyc = -1, lock_fall_cyc = -1, errh_rise_cyc = -1, errv_rise_cyc = -1;
  int done_cnt = 0, last_sum = -1, act_cnt = 0, idle_bad = 0;
  int first_act_cyc = -1, first_h = -1, first_v = -1, max_h = -1, max_v = -1;

  always @(negedge clk) begin
    prev_locked <= locked_o;
    prev_errh   <= err_hlen_o;
    prev_errv   <= err_vlen_o;
    if (locked_o && !prev_locked) lock_rise_cyc <= cyc;
    if (!locked_o && prev_locked) lock_fall_cyc <= cyc;
    if (err_hlen_o && !prev_errh) errh_rise_cyc <= cyc;
    if (err_vlen_o && !prev_errv) errv_rise_cyc <= cyc;
    if (frame_done_o) begin
      done_cnt <= done_cnt + 1;
      last_sum <= int'(frame_sum_o);
    end
    if (active_o) begin
      act_cnt <= act_cnt + 1;
      if (!seen_act) begin
        seen_act      <= 1'b1;
        first_act_cyc <= cyc;
        first_h       <= int'(hpos_o);
        first_v       <= int'(vpos_o);
      end
      if (int'(hpos_o) > max_h) max_h <= int'(hpos_o);
      if (int'(vpos_o) > max_v) max_v <= int'(vpos_o);
    end else if (hpos_o != 10'd0 || vpos_o != 10'd0) begin
      idle_bad <= idle_bad + 1;
    end
  end

  int n_checks = 0;
  int n_bad    = 0;
  int fs       = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pix(input int h, input int v, input int r, input int g, input int b);
    hsync_ni = (h >= HS);
    vsync_ni = (v >= VS);
    red_i    = 8'(r);
    green_i  = 8'(g);
    blue_i   = 8'(b);
    if (h == 0 && v == 0) fs = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int v, input int len, input int r, input int g, input int b);
    for (int h = 0; h < len; h++) pix(h, v, r, g, b);
  endtask

  task automatic frame(input int nl, input int short_v, input int r, input int g, input int b);
    for (int v = 0; v < nl; v++) line(v, (v == short_v) ? HT - 1 : HT, r, g, b);
  endtask

  int act0;

  initial begin
    reset_ni = 1'b0;
    hsync_ni = 1'b1;
    vsync_ni = 1'b1;
    red_i = '0; green_i = '0; blue_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_active", int'(active_o), 0);
    chk("rst_hpos", int'(hpos_o), 0);
    chk("rst_vpos", int'(vpos_o), 0);
    chk("rst_done", int'(frame_done_o), 0);
    chk("rst_sum", int'(frame_sum_o), 0);
    chk("rst_errh", int'(err_hlen_o), 0);
    chk("rst_errv", int'(err_vlen_o), 0);
    reset_ni = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // A: first vsync fall, B: locks at its start and is the first locked frame.
    frame(VT, -1, 1, 0, 0);
    chk("verify_not_locked", int'(locked_o), 0);
    act0 = act_cnt;
    frame(VT, -1, 1, 0, 0);
    chk("lock_rise_b", lock_rise_cyc, fs + 2);
    chk("first_act_cyc", first_act_cyc, fs + 4 * HT + 5 + 2);
    chk("first_hpos", first_h, 0);
    chk("first_vpos", first_v, 0);
    chk("act_count_b", act_cnt - act0, HV * VV);

    frame(VT, -1, 3, 5, 7);
    chk("done_cnt_c", done_cnt, 1);
    chk("sum_b", last_sum, SUM_B);

    // D: line 6 one cycle short while locked.
    frame(VT, 6, 0, 0, 0);
    chk("done_cnt_d", done_cnt, 2);
    chk("sum_c", last_sum, SUM_C);
    chk("errh_rise", errh_rise_cyc, fs + 6 * HT + (HT - 1) + 2);
    chk("lock_fall_h", lock_fall_cyc, fs + 6 * HT + (HT - 1) + 2);
    chk("errv_still0", int'(err_vlen_o), 0);

    frame(VT, -1, 0, 0, 0);
    chk("done_cnt_e", done_cnt, 2);
    chk("unlocked_e", int'(locked_o), 0);

    // F: relocks at its start, then is one line short.
    frame(VT - 1, -1, 0, 0, 0);
    chk("lock_rise_f", lock_rise_cyc, fs + 2);
    frame(VT, -1, 0, 0, 0);
    chk("errv_rise", errv_rise_cyc, fs + 2);
    chk("lock_fall_v", lock_fall_cyc, fs + 2);
    chk("done_cnt_g", done_cnt, 2);
    chk("errh_sticky", int'(err_hlen_o), 1);

    // H then I: relock, reset mid-frame while a visible pixel is on the outputs.
    frame(VT, -1, 0, 0, 0);
    for (int v = 0; v < 5; v++) line(v, HT, 0, 0, 0);
    for (int h = 0; h < 10; h++) pix(h, 5, 0, 0, 0);
    chk("pre_rst_locked", int'(locked_o), 1);
    chk("pre_rst_active", int'(active_o), 1);
    chk("pre_rst_hpos", int'(hpos_o), 3);
    chk("pre_rst_vpos", int'(vpos_o), 1);
    reset_ni = 1'b0;
    #1;
    chk("mid_rst_locked", int'(locked_o), 0);
    chk("mid_rst_active", int'(active_o), 0);
    chk("mid_rst_hpos", int'(hpos_o), 0);
    chk("mid_rst_vpos", int'(vpos_o), 0);
    chk("mid_rst_errh", int'(err_hlen_o), 0);
    chk("mid_rst_errv", int'(err_vlen_o), 0);
    chk("mid_rst_sum", int'(frame_sum_o), 0);
    chk("mid_rst_done", int'(frame_done_o), 0);
    pix(10, 5, 0, 0, 0);
    pix(11, 5, 0, 0, 0);
    reset_ni = 1'b1;
    for (int h = 12; h < HT; h++) pix(h, 5, 0, 0, 0);
    for (int v = 6; v < VT; v++) line(v, HT, 0, 0, 0);

    frame(VT, -1, 0, 0, 0);
    chk("post_rst_unlocked", int'(locked_o), 0);
    frame(VT, -1, 255, 255, 255);
    chk("lock_rise_k", lock_rise_cyc, fs + 2);
    line(0, HT, 0, 0, 0);
    line(1, HT, 0, 0, 0);
    chk("done_cnt_l", done_cnt, 3);
    chk("sum_k", last_sum, SUM_K);
    chk("errh_after_rst", int'(err_hlen_o), 0);

    chk("max_hpos", max_h, HV - 1);
    chk("max_vpos", max_v, VV - 1);
    chk("idle_pos_nonzero", idle_bad, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
